vram_arbiter: RTL and testbench



---
 rtl/vram_arbiter_pkg.sv | 19 +
 rtl/vram_arbiter_if.sv | 32 +++
 rtl/vram_arbiter_pixel_shifter.sv | 24 ++
 rtl/vram_arbiter.sv | 139 +++++++++++++
 tb/tb_vram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared defaults, FSM state encoding and slot phase
// constants for the video RAM arbiter.
package vram_arbiter_pkg;

  localparam int DEFAULT_BYTES_PER_LINE = 48;
  localparam int DEFAULT_ADDR_WIDTH     = 13;
  localparam int DEFAULT_BASE_ADDR      = 0;

  // Phases within each 8-clock group of an active line.
  localparam logic [2:0] VIDEO_PHASE   = 3'd0;  // video fetch slot
  localparam logic [2:0] CAPTURE_PHASE = 3'd1;  // RAM data of the fetch is valid
  localparam logic [2:0] LOAD_PHASE    = 3'd7;  // hand the byte to the shifter

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LINE = 1'b1
  } state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: CPU req/ack bus plus the single-port video RAM bus.
// slave = arbiter side, master = CPU / RAM side.
interface vram_arbiter_if
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

  logic                  cpuReq;
  logic                  cpuWe;
  logic [ADDR_WIDTH-1:0] cpuAddr;
  logic [7:0]            cpuWdata;
  logic                  cpuAck;
  logic [7:0]            cpuRdata;

  logic                  memEn;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [7:0]            memWdata;
  logic [7:0]            memRdata;

  modport slave (
    input  cpuReq, cpuWe, cpuAddr, cpuWdata, memRdata,
    output cpuAck, cpuRdata, memEn, memWe, memAddr, memWdata
  );

  modport master (
    output cpuReq, cpuWe, cpuAddr, cpuWdata, memRdata,
    input  cpuAck, cpuRdata, memEn, memWe, memAddr, memWdata
  );

endinterface

// File: rtl/vram_arbiter_pixel_shifter.sv
// vram_arbiter_pixel_shifter (PixelShifter): 8-bit parallel-load register
// that shifts left every cycle, zero-filling; pixel is bit 7 (MSB first).
module vram_arbiter_pixel_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       pixel
);

  logic [7:0] shift;

  // Load a new byte or shift out one pixel per clock.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state so every register
    // samples pre-edge values regardless of statement order.
    if (reset)     shift <= '0;
    else if (load) shift <= data;
    else           shift <= {shift[6:0], 1'b0};
  end

  assign pixel = shift[7];

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video RAM between CPU accesses and
// display scan-out (one fixed fetch slot per 8-clock group during a line),
// serialising fetched bytes into a 1-bit pixel stream.
// Optional feature: `VRAM_ARB_CONTENTION_COUNT_EN enables the CPU stall counter.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int BYTES_PER_LINE = DEFAULT_BYTES_PER_LINE,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int BASE_ADDR      = DEFAULT_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frameStart,
  input  logic                 lineStart,
  vram_arbiter_if.slave        bus,
  output logic                 pixel,
  output logic [15:0]          contentionCount
);

  localparam int COUNT_WIDTH = $clog2(BYTES_PER_LINE + 1);
  localparam logic [ADDR_WIDTH-1:0]  BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [COUNT_WIDTH-1:0] LINE_LAST = COUNT_WIDTH'(BYTES_PER_LINE);

  state_t                  state, state_next;
  logic [2:0]              phase;
  logic [COUNT_WIDTH-1:0]  byte_count;
  logic [ADDR_WIDTH-1:0]   vid_addr;
  logic [7:0]              hold;
  logic                    fetched;
  logic                    cpu_ack;
  logic                    video_slot;
  logic                    cpu_grant;
  logic                    shift_load;

  // Scan-out slot always wins; the CPU is granted any other cycle unless an
  // ack is already pending, which limits it to one access per 2 cycles.
  assign video_slot = (state == ST_LINE) && (phase == VIDEO_PHASE) &&
                      (byte_count < LINE_LAST);
  assign cpu_grant  = bus.cpuReq && !video_slot && !cpu_ack;
  assign shift_load = (state == ST_LINE) && (phase == LOAD_PHASE) && fetched;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: a line ends at the load phase of its last fetch group.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    case (state)
      ST_IDLE: if (lineStart) state_next = ST_LINE;
      ST_LINE: begin
        if (lineStart)
          state_next = ST_LINE;
        else if ((phase == LOAD_PHASE) && (byte_count == LINE_LAST))
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // RAM port mux: video fetch, else CPU grant, else idle.
  always_comb begin
    bus.memEn    = 1'b0;
    bus.memWe    = 1'b0;
    bus.memAddr  = '0;
    bus.memWdata = '0;
    if (video_slot) begin
      bus.memEn   = 1'b1;
      bus.memAddr = vid_addr;
    end else if (cpu_grant) begin
      bus.memEn    = 1'b1;
      bus.memWe    = bus.cpuWe;
      bus.memAddr  = bus.cpuAddr;
      bus.memWdata = bus.cpuWdata;
    end
  end

  // Line sequencing, video address, holding register and CPU ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= '0;
      byte_count <= '0;
      vid_addr   <= BASE;
      hold       <= '0;
      fetched    <= 1'b0;
      cpu_ack    <= 1'b0;
    end else begin
      cpu_ack <= cpu_grant;

      if (lineStart) begin
        phase      <= '0;
        byte_count <= '0;
      end else if (state == ST_LINE) begin
        phase <= phase + 3'd1;
        if (video_slot) byte_count <= byte_count + COUNT_WIDTH'(1);
      end

      // frameStart has priority so a simultaneous lineStart fetches BASE first.
      if (frameStart)      vid_addr <= BASE;
      else if (video_slot) vid_addr <= vid_addr + ADDR_WIDTH'(1);

      if ((state == ST_LINE) && (phase == CAPTURE_PHASE)) hold    <= bus.memRdata;
      if ((state == ST_LINE) && (phase == VIDEO_PHASE))   fetched <= video_slot;
    end
  end

  // RAM read data arrives in the ack cycle, so it is passed straight through.
  assign bus.cpuAck   = cpu_ack;
  assign bus.cpuRdata = cpu_ack ? bus.memRdata : 8'h00;

  vram_arbiter_pixel_shifter u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (shift_load),
    .data  (hold),
    .pixel (pixel)
  );

`ifdef VRAM_ARB_CONTENTION_COUNT_EN
  logic [15:0] contention_q;

  // Saturating count of cycles a pending CPU request loses to a video slot.
  always_ff @(posedge clk) begin
    if (reset || frameStart)
      contention_q <= '0;
    else if (bus.cpuReq && video_slot && !cpu_ack && (contention_q != 16'hFFFF))
      contention_q <= contention_q + 16'd1;
  end

  assign contentionCount = contention_q;
`else
  assign contentionCount = 16'h0000;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench for vram_arbiter with a behavioural
// synchronous single-port RAM (read data valid one cycle after enable).
module tb_vram_arbiter;

  localparam int AW = 13;
`ifdef VRAM_ARB_CONTENTION_COUNT_EN
  localparam logic [15:0] EXP_CONT = 16'd1;
`else
  localparam logic [15:0] EXP_CONT = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        frameStart;
  logic        lineStart;
  logic        pixel;
  logic [15:0] contentionCount;
  logic [7:0]  ram [0:(1<<AW)-1];

  int tests = 0;
  int fails = 0;

  vram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  vram_arbiter #(
    .BYTES_PER_LINE (48),
    .ADDR_WIDTH     (AW),
    .BASE_ADDR      (0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .frameStart      (frameStart),
    .lineStart       (lineStart),
    .bus             (bus),
    .pixel           (pixel),
    .contentionCount (contentionCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.memEn) begin
      if (bus.memWe) ram[bus.memAddr] <= bus.memWdata;
      bus.memRdata <= ram[bus.memAddr];
    end
  end

  // Advance to just after the next rising edge (start of a new cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    tests++; if (pixel !== 1'b0) begin fails++; $display("FAIL reset_pixel got %b want 0", pixel); end
    tests++; if (bus.cpuAck !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", bus.cpuAck); end
    tests++; if (bus.cpuRdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h want 00", bus.cpuRdata); end
    tests++; if (bus.memEn !== 1'b0) begin fails++; $display("FAIL reset_memen got %b want 0", bus.memEn); end
    tests++; if (contentionCount !== 16'h0) begin fails++; $display("FAIL reset_count got %h want 0", contentionCount); end
    tick();
    reset = 1'b0;
  endtask

  // One full line of 8'hA5 bytes starting at address 0.
  task automatic test_line();
    logic [7:0] pat;
    logic       exp_pix;
    int         j;
    pat = 8'hA5;
    lineStart = 1'b1;
    tick();
    lineStart = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      j = i - 9;
      exp_pix = (j >= 0 && j < 384) ? pat[7 - (j % 8)] : 1'b0;
      tests++;
      if (pixel !== exp_pix) begin
        fails++; $display("FAIL line_pixel at +%0d got %b want %b", i, pixel, exp_pix);
      end
      tests++;
      if (((i - 1) % 8 == 0) && ((i - 1) / 8 < 48)) begin
        if ({bus.memEn, bus.memWe, bus.memAddr} !== {1'b1, 1'b0, AW'((i - 1) / 8)}) begin
          fails++; $display("FAIL line_fetch at +%0d got en=%b we=%b addr=%h want addr=%h",
                            i, bus.memEn, bus.memWe, bus.memAddr, (i - 1) / 8);
        end
      end else if (bus.memEn !== 1'b0) begin
        fails++; $display("FAIL line_idle_slot at +%0d got memEn=%b want 0", i, bus.memEn);
      end
      tick();
    end
  endtask

  task automatic test_cpu_write_read();
    bus.cpuReq = 1'b1; bus.cpuWe = 1'b1; bus.cpuAddr = 13'h100; bus.cpuWdata = 8'h3C;
    @(negedge clk);
    tests++;
    if ({bus.memEn, bus.memWe, bus.memAddr, bus.memWdata, bus.cpuAck} !== {1'b1, 1'b1, 13'h100, 8'h3C, 1'b0}) begin
      fails++; $display("FAIL wr_grant got en=%b we=%b addr=%h wd=%h ack=%b want 1 1 0100 3c 0",
                        bus.memEn, bus.memWe, bus.memAddr, bus.memWdata, bus.cpuAck);
    end
    tick();
    @(negedge clk);
    tests++; if (bus.cpuAck !== 1'b1) begin fails++; $display("FAIL wr_ack got %b want 1", bus.cpuAck); end
    tests++; if (bus.memEn !== 1'b0) begin fails++; $display("FAIL wr_no_grant_during_ack got %b want 0", bus.memEn); end
    tick();
    bus.cpuWe = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.memEn, bus.memWe, bus.memAddr, bus.cpuAck} !== {1'b1, 1'b0, 13'h100, 1'b0}) begin
      fails++; $display("FAIL rd_grant got en=%b we=%b addr=%h ack=%b want 1 0 0100 0",
                        bus.memEn, bus.memWe, bus.memAddr, bus.cpuAck);
    end
    tick();
    @(negedge clk);
    tests++; if (bus.cpuAck !== 1'b1) begin fails++; $display("FAIL rd_ack got %b want 1", bus.cpuAck); end
    tests++; if (bus.cpuRdata !== 8'h3C) begin fails++; $display("FAIL rd_data got %h want 3c", bus.cpuRdata); end
    tick();
    bus.cpuReq = 1'b0;
    @(negedge clk);
    tests++; if (bus.cpuAck !== 1'b0) begin fails++; $display("FAIL rd_ack_single got %b want 0", bus.cpuAck); end
    tick();
  endtask

  // Request arrives exactly on the first video slot of a line.
  task automatic test_contention();
    frameStart = 1'b1; lineStart = 1'b1;
    tick();
    frameStart = 1'b0; lineStart = 1'b0;
    bus.cpuReq = 1'b1; bus.cpuWe = 1'b0; bus.cpuAddr = 13'h100;
    @(negedge clk);
    tests++;
    if ({bus.memEn, bus.memWe, bus.memAddr, bus.cpuAck} !== {1'b1, 1'b0, 13'h000, 1'b0}) begin
      fails++; $display("FAIL cont_slot got en=%b we=%b addr=%h ack=%b want 1 0 0000 0",
                        bus.memEn, bus.memWe, bus.memAddr, bus.cpuAck);
    end
    tick();
    @(negedge clk);
    tests++;
    if ({bus.memEn, bus.memWe, bus.memAddr, bus.cpuAck} !== {1'b1, 1'b0, 13'h100, 1'b0}) begin
      fails++; $display("FAIL cont_grant got en=%b we=%b addr=%h ack=%b want 1 0 0100 0",
                        bus.memEn, bus.memWe, bus.memAddr, bus.cpuAck);
    end
    tick();
    @(negedge clk);
    tests++; if (bus.cpuAck !== 1'b1) begin fails++; $display("FAIL cont_ack got %b want 1", bus.cpuAck); end
    tests++; if (bus.cpuRdata !== 8'h3C) begin fails++; $display("FAIL cont_rdata got %h want 3c", bus.cpuRdata); end
    tests++; if (contentionCount !== EXP_CONT) begin fails++; $display("FAIL cont_count got %0d want %0d", contentionCount, EXP_CONT); end
    tick();
    bus.cpuReq = 1'b0;
    idle_cycles(400);
  endtask

  // Second line continues at 48; a mid-line frameStart+lineStart restarts at 0.
  task automatic test_two_lines();
    lineStart = 1'b1;
    tick();
    lineStart = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1 || i == 9) begin
        tests++;
        if ({bus.memEn, bus.memAddr} !== {1'b1, AW'(48 + (i - 1) / 8)}) begin
          fails++; $display("FAIL line2_fetch at +%0d got en=%b addr=%h want 1 %h",
                            i, bus.memEn, bus.memAddr, 48 + (i - 1) / 8);
        end
      end
      tick();
    end
    frameStart = 1'b1; lineStart = 1'b1;
    tick();
    frameStart = 1'b0; lineStart = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1 || i == 9) begin
        tests++;
        if ({bus.memEn, bus.memAddr} !== {1'b1, AW'((i - 1) / 8)}) begin
          fails++; $display("FAIL frame_fetch at +%0d got en=%b addr=%h want 1 %h",
                            i, bus.memEn, bus.memAddr, (i - 1) / 8);
        end
      end
      tick();
    end
    idle_cycles(400);
  endtask

  // Held request: grants on even cycles, acks on odd, slots fall on ack cycles.
  task automatic test_back_to_back();
    frameStart = 1'b1; lineStart = 1'b1;
    bus.cpuReq = 1'b1; bus.cpuWe = 1'b0; bus.cpuAddr = 13'h100;
    for (int i = 0; i <= 24; i++) begin
      @(negedge clk);
      tests++;
      if (bus.cpuAck !== 1'((i % 2) == 1)) begin
        fails++; $display("FAIL b2b_ack at +%0d got %b want %b", i, bus.cpuAck, (i % 2) == 1);
      end
      if (i % 2 == 0) begin
        tests++;
        if ({bus.memEn, bus.memWe, bus.memAddr} !== {1'b1, 1'b0, 13'h100}) begin
          fails++; $display("FAIL b2b_grant at +%0d got en=%b we=%b addr=%h want 1 0 0100",
                            i, bus.memEn, bus.memWe, bus.memAddr);
        end
      end else begin
        tests++;
        if (bus.cpuRdata !== 8'h3C) begin
          fails++; $display("FAIL b2b_rdata at +%0d got %h want 3c", i, bus.cpuRdata);
        end
        tests++;
        if ((i - 1) % 8 == 0) begin
          if ({bus.memEn, bus.memWe, bus.memAddr} !== {1'b1, 1'b0, AW'((i - 1) / 8)}) begin
            fails++; $display("FAIL b2b_slot at +%0d got en=%b we=%b addr=%h want 1 0 %h",
                              i, bus.memEn, bus.memWe, bus.memAddr, (i - 1) / 8);
          end
        end else if (bus.memEn !== 1'b0) begin
          fails++; $display("FAIL b2b_blocked at +%0d got memEn=%b want 0", i, bus.memEn);
        end
      end
      tick();
      frameStart = 1'b0; lineStart = 1'b0;
    end
    bus.cpuReq = 1'b0;
    idle_cycles(400);
  endtask

  // Reset sampled at the end of a grant cycle mid-line.
  task automatic test_reset_mid_access();
    lineStart = 1'b1;
    tick();
    lineStart = 1'b0;
    idle_cycles(2);
    bus.cpuReq = 1'b1; bus.cpuWe = 1'b0; bus.cpuAddr = 13'h100;
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.memEn, bus.memAddr} !== {1'b1, 13'h100}) begin
      fails++; $display("FAIL rst_grant got en=%b addr=%h want 1 0100", bus.memEn, bus.memAddr);
    end
    tick();
    reset = 1'b0;
    bus.cpuReq = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.cpuAck, bus.cpuRdata, bus.memEn, pixel, contentionCount} !== {1'b0, 8'h00, 1'b0, 1'b0, 16'h0}) begin
        fails++; $display("FAIL rst_quiet at +%0d got ack=%b rd=%h en=%b pix=%b cnt=%h want all 0",
                          i, bus.cpuAck, bus.cpuRdata, bus.memEn, pixel, contentionCount);
      end
      tick();
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) ram[a] = (a < 48) ? 8'hA5 : 8'h00;
    reset = 1'b1; frameStart = 1'b0; lineStart = 1'b0;
    bus.cpuReq = 1'b0; bus.cpuWe = 1'b0; bus.cpuAddr = '0; bus.cpuWdata = 8'h00;
    tick();
    test_reset();
    test_line();
    test_cpu_write_read();
    test_contention();
    test_two_lines();
    test_back_to_back();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
